// File: rtl/handwrite_submit_ctrl.sv
// Submit sequencer for the handwriting canvas: snapshots the bitmap, streams it row by row
// to the recognizer, waits for a result with timeout, then drives the clear/scroll displacement.
module handwrite_submit_ctrl #(
    parameter int unsigned SCROLL_MAX  = 150,
    parameter int unsigned SCROLL_STEP = 1,
    parameter int unsigned SCROLL_DIV  = 50000,
    parameter int unsigned TIMEOUT     = 5000000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_submit,
    input  logic         i_abort,
    input  logic [899:0] i_handwrite,
    output logic         o_row_valid,
    input  logic         i_row_ready,
    output logic [29:0]  o_row_data,
    output logic [4:0]   o_row_idx,
    input  logic         i_result_valid,
    input  logic [3:0]   i_result,
    output logic [3:0]   o_result,
    output logic         o_error,
    output logic [10:0]  o_displacement,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_SCROLL} state_t;

    localparam logic [11:0] MAX12    = 12'(SCROLL_MAX);
    localparam logic [10:0] MAX11    = 11'(SCROLL_MAX);
    localparam logic [31:0] DIV_LAST = 32'(SCROLL_DIV - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t        state_q;
    logic [899:0]  snap_q;
    logic [4:0]    row_q;
    logic          valid_q;
    logic [31:0]   tmo_q;
    logic [31:0]   div_q;
    logic [10:0]   disp_q;
    logic [3:0]    result_q;
    logic          error_q;
    logic          done_q;

    logic [11:0]   disp_sum;
    logic [10:0]   disp_d;

    // Saturate in 12 bits so the 11-bit displacement can never wrap.
    assign disp_sum = {1'b0, disp_q} + 12'(SCROLL_STEP);
    assign disp_d   = (disp_sum >= MAX12) ? MAX11 : disp_sum[10:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            snap_q   <= '0;
            row_q    <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= '0;
            div_q    <= '0;
            disp_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                disp_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_submit && !i_abort) begin
                            snap_q  <= i_handwrite;
                            row_q   <= '0;
                            error_q <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        // Snapshot shifts down one row per transfer so the current row sits in [29:0].
                        if (i_row_ready) begin
                            if (row_q == 5'd29) begin
                                valid_q <= 1'b0;
                                tmo_q   <= '0;
                                state_q <= S_WAIT;
                            end else begin
                                row_q  <= row_q + 5'd1;
                                snap_q <= {30'b0, snap_q[899:30]};
                            end
                        end
                    end
                    S_WAIT: begin
                        if (i_result_valid) begin
                            result_q <= i_result;
                            div_q    <= '0;
                            state_q  <= S_SCROLL;
                        end else if (tmo_q == TMO_LAST) begin
                            result_q <= 4'hF;
                            error_q  <= 1'b1;
                            div_q    <= '0;
                            state_q  <= S_SCROLL;
                        end else begin
                            tmo_q <= tmo_q + 32'd1;
                        end
                    end
                    S_SCROLL: begin
                        if (disp_q == MAX11) begin
                            disp_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (div_q == DIV_LAST) begin
                            div_q  <= '0;
                            disp_q <= disp_d;
                        end else begin
                            div_q <= div_q + 32'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_row_valid    = valid_q;
    assign o_row_data     = snap_q[29:0];
    assign o_row_idx      = row_q;
    assign o_result       = result_q;
    assign o_error        = error_q;
    assign o_displacement = disp_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = done_q;

endmodule
